// File: rtl/lab3_mem_line_mem_responder.sv
// Line-wide backing memory for the 16B cache refill/evict interface.
// One blocking transaction in flight; the response is returned a fixed p_latency cycles after accept.
//
// state    | meaning
// ST_IDLE  | ready for a request; storage is accessed in the accept cycle
// ST_DELAY | latency down-counter running; leaves when the count reaches 1
// ST_RESP  | response valid and held stable until the consumer takes it
module lab3_mem_line_mem_responder #(
    parameter int p_num_lines = 256,
    parameter int p_latency   = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [174:0] memreq_msg_i,
    input  logic         memreq_val_i,
    output logic         memreq_rdy_o,
    output logic [144:0] memresp_msg_o,
    output logic         memresp_val_o,
    input  logic         memresp_rdy_i
);
    localparam int IDX_W = $clog2(p_num_lines);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [2:0] TYPE_READ  = 3'd0;
    localparam logic [2:0] TYPE_WRITE = 3'd1;
    localparam logic [2:0] TYPE_INIT  = 3'd2;

    localparam logic [3:0] LAT = 4'(p_latency);

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [2:0]   type_q, type_d;
    logic [7:0]   opq_q, opq_d;
    logic [3:0]   len_q, len_d;
    logic [127:0] data_q, data_d;

    logic [127:0] mem_q [p_num_lines];

    logic [2:0]       req_type;
    logic [7:0]       req_opq;
    logic [31:0]      req_addr;
    logic [3:0]       req_len;
    logic [127:0]     req_data;
    logic [3:0]       req_off;
    logic [IDX_W-1:0] req_idx;

    logic         accept;
    logic         is_write;
    logic [15:0]  lane_mask;
    logic [127:0] bit_mask;
    logic [127:0] wr_data;
    logic [127:0] line_rd;
    logic [127:0] line_wr;
    logic [127:0] rd_data;

    logic unused_addr_hi;

    assign req_type = memreq_msg_i[174:172];
    assign req_opq  = memreq_msg_i[171:164];
    assign req_addr = memreq_msg_i[163:132];
    assign req_len  = memreq_msg_i[131:128];
    assign req_data = memreq_msg_i[127:0];
    assign req_off  = req_addr[3:0];
    assign req_idx  = req_addr[4 +: IDX_W];

    // Upper address bits only alias lines; they never select storage.
    assign unused_addr_hi = ^req_addr[31:4+IDX_W];

    assign memreq_rdy_o  = (state_q == ST_IDLE) && rst_n_i;
    assign memresp_val_o = (state_q == ST_RESP);
    assign memresp_msg_o = {type_q, opq_q, 2'b00, len_q, data_q};

    assign accept   = memreq_val_i && memreq_rdy_o;
    assign is_write = (req_type == TYPE_WRITE) || (req_type == TYPE_INIT);

    always_comb begin
        // Partial writes cover lanes off..off+len-1; lanes past 15 fall off the line.
        for (int i = 0; i < 16; i++) begin
            lane_mask[i] = (req_len == 4'd0) ||
                           (({1'b0, 4'(i)} >= {1'b0, req_off}) &&
                            ({1'b0, 4'(i)} <  ({1'b0, req_off} + {1'b0, req_len})));
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
        wr_data = (req_len == 4'd0) ? req_data : (req_data << {req_off, 3'b000});
        line_rd = mem_q[req_idx];
        line_wr = (line_rd & ~bit_mask) | (wr_data & bit_mask);
        rd_data = (req_len == 4'd0) ? line_rd : (line_rd >> {req_off, 3'b000});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        opq_d   = opq_q;
        len_d   = len_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    type_d  = req_type;
                    opq_d   = req_opq;
                    len_d   = req_len;
                    data_d  = (req_type == TYPE_READ) ? rd_data : 128'd0;
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? ST_RESP : ST_DELAY;
                end
            end
            ST_DELAY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (memresp_rdy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            type_q  <= 3'd0;
            opq_q   <= 8'd0;
            len_q   <= 4'd0;
            data_q  <= 128'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            opq_q   <= opq_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

    // Storage survives reset, so a write done at accept is kept even if the response is dropped.
    always_ff @(posedge clk_i) begin
        if (accept && is_write) begin
            mem_q[req_idx] <= line_wr;
        end
    end

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// Bench for the line memory responder: three instances (latency 2, 0, 3) checked against
// a byte-array reference model with directed scenarios followed by randomized traffic.
module tb_lab3_mem_line_mem_responder;
    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_WRITE = 3'd1;
    localparam logic [2:0] T_INIT  = 3'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [174:0] req_msg [3];
    logic         req_val [3];
    logic         req_rdy [3];
    logic [144:0] rsp_msg [3];
    logic         rsp_val [3];
    logic         rsp_rdy [3];

    int errors = 0;
    int checks = 0;

    logic [7:0]   mb [3][256][16];
    logic [144:0] exp_msg [3];
    logic [144:0] last_rsp [3];

    lab3_mem_line_mem_responder #(.p_num_lines(256), .p_latency(2)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .memreq_msg_i(req_msg[0]), .memreq_val_i(req_val[0]), .memreq_rdy_o(req_rdy[0]),
        .memresp_msg_o(rsp_msg[0]), .memresp_val_o(rsp_val[0]), .memresp_rdy_i(rsp_rdy[0]));

    lab3_mem_line_mem_responder #(.p_num_lines(256), .p_latency(0)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .memreq_msg_i(req_msg[1]), .memreq_val_i(req_val[1]), .memreq_rdy_o(req_rdy[1]),
        .memresp_msg_o(rsp_msg[1]), .memresp_val_o(rsp_val[1]), .memresp_rdy_i(rsp_rdy[1]));

    lab3_mem_line_mem_responder #(.p_num_lines(256), .p_latency(3)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .memreq_msg_i(req_msg[2]), .memreq_val_i(req_val[2]), .memreq_rdy_o(req_rdy[2]),
        .memresp_msg_o(rsp_msg[2]), .memresp_val_o(rsp_val[2]), .memresp_rdy_i(rsp_rdy[2]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [174:0] obs, input logic [174:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: storage as 16 bytes per line, updated when the request is accepted.
    task automatic model_apply(input int k, input logic [2:0] t, input logic [7:0] opq,
                               input logic [31:0] addr, input logic [3:0] len, input logic [127:0] data);
        int idx;
        int off;
        logic [127:0] rd;
        idx = int'(addr[11:4]);
        off = int'(addr[3:0]);
        rd  = '0;
        if (t == T_READ) begin
            for (int j = 0; j < 16; j++) begin
                if (len == 4'd0) rd[8*j +: 8] = mb[k][idx][j];
                else if (off + j < 16) rd[8*j +: 8] = mb[k][idx][off + j];
            end
        end else if (t == T_WRITE || t == T_INIT) begin
            if (len == 4'd0) begin
                for (int j = 0; j < 16; j++) mb[k][idx][j] = data[8*j +: 8];
            end else begin
                for (int j = 0; j < int'(len); j++)
                    if (off + j < 16) mb[k][idx][off + j] = data[8*j +: 8];
            end
        end
        exp_msg[k] = {t, opq, 2'b00, len, rd};
    endtask

    task automatic send_req(input int k, input logic [2:0] t, input logic [7:0] opq,
                            input logic [31:0] addr, input logic [3:0] len, input logic [127:0] data);
        int n;
        req_msg[k] = {t, opq, addr, len, data};
        req_val[k] = 1'b1;
        n = 0;
        while (req_rdy[k] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("accept_wait_bound", 175'(n < 50), 175'(1));
        tick();
        req_val[k] = 1'b0;
        model_apply(k, t, opq, addr, len, data);
    endtask

    task automatic wait_resp(input int k, input int hold, input bit junk);
        int n;
        bit busy_ok;
        bit stable;
        busy_ok = 1'b1;
        stable  = 1'b1;
        if (junk) begin
            req_msg[k] = {T_WRITE, 8'hee, 32'h0000_0070, 4'd0, {4{32'heeee_eeee}}};
            req_val[k] = 1'b1;
        end
        n = 1;
        while (rsp_val[k] !== 1'b1 && n < 40) begin
            if (req_rdy[k] !== 1'b0) busy_ok = 1'b0;
            tick();
            n++;
        end
        check("resp_latency", 175'(n), 175'(1 + lat_of(k)));
        if (lat_of(k) > 0) check("delay_rdy_low", 175'(busy_ok), 175'(1));
        check("resp_msg", 175'(rsp_msg[k]), 175'(exp_msg[k]));
        check("resp_rdy_low", 175'(req_rdy[k]), 175'(0));
        last_rsp[k] = rsp_msg[k];
        for (int h = 0; h < hold; h++) begin
            tick();
            if (rsp_val[k] !== 1'b1 || rsp_msg[k] !== last_rsp[k] || req_rdy[k] !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check("resp_hold_stable", 175'(stable), 175'(1));
        rsp_rdy[k] = 1'b1;
        tick();
        rsp_rdy[k] = 1'b0;
        req_val[k] = 1'b0;
        check("post_resp_val", 175'(rsp_val[k]), 175'(0));
        check("post_resp_rdy", 175'(req_rdy[k]), 175'(1));
    endtask

    task automatic txn(input int k, input logic [2:0] t, input logic [7:0] opq, input logic [31:0] addr,
                       input logic [3:0] len, input logic [127:0] data, input int hold, input bit junk);
        send_req(k, t, opq, addr, len, data);
        wait_resp(k, hold, junk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d5;
        logic [127:0] d6;
        logic [2:0]   t;
        logic [3:0]   len;
        logic [31:0]  addr;
        int           sel;
        int           k;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_msg[i] = '0;
            req_val[i] = 1'b0;
            rsp_rdy[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_req_rdy", 175'(req_rdy[i]), 175'(0));
            check("reset_resp_val", 175'(rsp_val[i]), 175'(0));
            check("reset_resp_msg", 175'(rsp_msg[i]), 175'(0));
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("idle_req_rdy", 175'(req_rdy[i]), 175'(1));
            check("idle_resp_val", 175'(rsp_val[i]), 175'(0));
        end

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 8; j++)
                txn(i, T_INIT, 8'(j), ($urandom() & 32'hffff_f000) | 32'(j << 4), 4'd0, rand128(), 0, 0);

        // INIT a known line then read it back
        txn(0, T_INIT, 8'h01, 32'h0000_1000, 4'd0, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 0, 0);
        txn(0, T_READ, 8'h05, 32'h0000_1000, 4'd0, rand128(), 0, 0);
        check("T1_data", 175'(last_rsp[0][127:0]), 175'(128'h0f0e0d0c_0b0a0908_07060504_03020100));
        check("T1_header", 175'(last_rsp[0][144:128]), 175'({3'd0, 8'h05, 2'b00, 4'd0}));

        // Partial write into lanes 7:4
        txn(0, T_WRITE, 8'h22, 32'h0000_1004, 4'd4, 128'hdead_beef, 0, 0);
        check("T2_write_resp_data", 175'(last_rsp[0][127:0]), 175'(0));
        txn(0, T_READ, 8'h23, 32'h0000_1000, 4'd0, '0, 0, 0);
        check("T2_line", 175'(last_rsp[0][127:0]), 175'(128'h0f0e0d0c_0b0a0908_deadbeef_03020100));

        // Latency 0 and 3 instances
        txn(1, T_READ, 8'h30, 32'h0000_0030, 4'd0, '0, 0, 0);
        txn(2, T_READ, 8'h33, 32'h0000_0030, 4'd0, '0, 0, 0);

        // Stalled consumer with a request pushed while busy (must be ignored)
        txn(0, T_READ, 8'h44, 32'h0000_1000, 4'd0, '0, 5, 1);
        check("T4_line", 175'(last_rsp[0][127:0]), 175'(128'h0f0e0d0c_0b0a0908_deadbeef_03020100));
        txn(0, T_READ, 8'h47, 32'habc0_0070, 4'd0, '0, 0, 0);

        // Address wrap modulo 256 lines
        d5 = rand128();
        txn(0, T_WRITE, 8'h50, 32'h0000_0010, 4'd0, d5, 0, 0);
        txn(0, T_READ, 8'h51, 32'h0000_1010, 4'd0, '0, 0, 0);
        check("T5_wrap", 175'(last_rsp[0][127:0]), 175'(d5));

        // Reset during DELAY drops the response but keeps the write
        d6 = rand128();
        send_req(0, T_WRITE, 8'h60, 32'h0000_0020, 4'd0, d6);
        tick();
        rst_n = 1'b0;
        #1;
        check("T6_reset_val", 175'(rsp_val[0]), 175'(0));
        check("T6_reset_rdy", 175'(req_rdy[0]), 175'(0));
        check("T6_reset_msg", 175'(rsp_msg[0]), 175'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("T6_after_val", 175'(rsp_val[0]), 175'(0));
        check("T6_after_rdy", 175'(req_rdy[0]), 175'(1));
        txn(0, T_READ, 8'h61, 32'h0000_0020, 4'd0, '0, 0, 0);
        check("T6_data_kept", 175'(last_rsp[0][127:0]), 175'(d6));

        for (int r = 0; r < 90; r++) begin
            k   = r % 3;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      t = T_READ;
            else if (sel < 6) t = T_WRITE;
            else if (sel < 8) t = T_INIT;
            else              t = 3'($urandom_range(3, 7));
            len  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            addr = ($urandom() & 32'hffff_f000) | 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 15));
            txn(k, t, 8'($urandom()), addr, len, rand128(), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
